// File: rtl/mem_fill_responder_pkg.sv
// Shared types and constants for the memory-side cache fill responder.
package mem_fill_responder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IC_FILL  = 2'd1,
    DC_FILL  = 2'd2,
    DC_WRITE = 2'd3
  } state_t;

  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;
  localparam logic [15:0] WORD_MASK  = 16'hFFFE;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  localparam int BEATS = 8;

  // One in-flight read response: who asked, which beat, and the word itself.
  typedef struct packed {
    logic        valid;
    logic        owner;
    logic [2:0]  beat;
    logic [15:0] data;
  } rsp_t;

endpackage

// File: rtl/mem_fill_responder_rsp_delay_pipe.sv
// Fixed-length delay line that lines up returned RAM words with their
// beat/owner tags so they reach the caches a fixed number of cycles after issue.
module mem_fill_responder_rsp_delay_pipe
  import mem_fill_responder_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  rsp_t din,
  output rsp_t dout
);

  rsp_t stage_q [STAGES];

  // Shift register; reset clears every stage so nothing in flight survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/mem_fill_responder.sv
// Memory-side responder: arbitrates the shared RAM between I-cache fills,
// D-cache fills and D-cache write-through, and returns fill words in order.
//
// state    | meaning
// IDLE     | no owner; requests sampled unless just returned (hold_q)
// IC_FILL  | I-cache block fill: entry cycle, 8 reads, drain
// DC_FILL  | D-cache block fill: entry cycle, 8 reads, drain
// DC_WRITE | D-cache write-through: entry cycle, one write, wait, ack
module mem_fill_responder
  import mem_fill_responder_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ic_req,
  input  logic [15:0] ic_addr,
  input  logic        dc_req,
  input  logic [15:0] dc_addr,
  input  logic        dc_wr,
  input  logic [15:0] dc_wdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        rsp_valid_ic,
  output logic        rsp_valid_dc,
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_beat,
  output logic        dc_wr_ack,
  output logic        wait_icache,
  output logic        busy
);

  // Fill: entry(0), issue(1..8), last cycle leaves so IDLE coincides with beat 7.
  localparam logic [3:0] FILL_LAST  = 4'(LATENCY + BEATS - 1);
  localparam logic [3:0] WRITE_LAST = 4'(LATENCY);
  localparam logic [3:0] ISSUE_LAST = 4'(BEATS);

  state_t      state_q, state_d;
  logic [3:0]  cyc_q;
  logic [15:0] base_q, wdata_q;
  logic        hold_q, ack_q;
  logic        issuing, writing, last;
  logic [2:0]  issue_cnt;
  logic        rd_valid_q, rd_owner_q;
  logic [2:0]  rd_beat_q;
  rsp_t        pipe_in, pipe_out;

  // Next-state selection and RAM strobe decode.
  always_comb begin
    state_d   = state_q;
    issuing   = 1'b0;
    writing   = 1'b0;
    last      = 1'b0;
    issue_cnt = cyc_q[2:0] - 3'd1;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = 16'h0000;
    ram_wdata = 16'h0000;
    case (state_q)
      IDLE: begin
        if (!hold_q) begin
          if (ic_req)      state_d = IC_FILL;
          else if (dc_wr)  state_d = DC_WRITE;
          else if (dc_req) state_d = DC_FILL;
        end
      end
      IC_FILL, DC_FILL: begin
        issuing = (cyc_q != 4'd0) && (cyc_q <= ISSUE_LAST);
        last    = (cyc_q == FILL_LAST);
      end
      DC_WRITE: begin
        writing = (cyc_q == 4'd1);
        last    = (cyc_q == WRITE_LAST);
      end
      default: state_d = IDLE;
    endcase
    if (last) state_d = IDLE;
    if (issuing) begin
      ram_en   = 1'b1;
      ram_addr = base_q | {12'd0, issue_cnt, 1'b0};
    end else if (writing) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = base_q;
      ram_wdata = wdata_q;
    end
  end

  // State, phase counter and the address/data latched on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= 4'd0;
      base_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      hold_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Block acceptance for the first IDLE cycle so a still-held level
      // request from the finished transaction is not taken twice.
      hold_q  <= (state_q != IDLE) && (state_d == IDLE);
      ack_q   <= (state_q == DC_WRITE) && last;
      cyc_q   <= (state_q == IDLE || state_d == IDLE) ? 4'd0 : cyc_q + 4'd1;
      if (state_q == IDLE) begin
        case (state_d)
          IC_FILL:  base_q <= ic_addr & BLOCK_MASK;
          DC_FILL:  base_q <= dc_addr & BLOCK_MASK;
          DC_WRITE: begin
            base_q  <= dc_addr & WORD_MASK;
            wdata_q <= dc_wdata;
          end
          default:  base_q <= base_q;
        endcase
      end
    end
  end

  // Tag register aligned with the RAM's one-cycle read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWNER_IC;
      rd_beat_q  <= 3'd0;
    end else begin
      rd_valid_q <= issuing;
      rd_owner_q <= (state_q == DC_FILL) ? OWNER_DC : OWNER_IC;
      rd_beat_q  <= issue_cnt;
    end
  end

  // Join the tag with the word coming back from RAM.
  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = rd_valid_q;
    pipe_in.owner = rd_owner_q;
    pipe_in.beat  = rd_beat_q;
    pipe_in.data  = ram_rdata;
  end

  mem_fill_responder_rsp_delay_pipe #(.STAGES(LATENCY - 1)) u_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  assign rsp_valid_ic = pipe_out.valid && (pipe_out.owner == OWNER_IC);
  assign rsp_valid_dc = pipe_out.valid && (pipe_out.owner == OWNER_DC);
  assign rsp_data     = pipe_out.data;
  assign rsp_beat     = pipe_out.beat;
  assign dc_wr_ack    = ack_q;
  assign busy         = (state_q != IDLE);
  // Gated by reset so every output reads 0 while rst_n is low.
  assign wait_icache  = rst_n && ((state_q == IC_FILL) || ((state_q == IDLE) && ic_req));

endmodule
